// File: rtl/full_adder_pg_pipe.sv
// full_adder_pg_pipe
//   Segmented, pipelined carry-propagate adder/subtractor for the
//   linearizer/normalizer datapath. Operands are cut into SEG-bit ripple
//   segments. A register stage sits between consecutive segments, and the
//   last stage is the output register, so a result appears NSEG cycles
//   after its operands are presented. Outputs: the sum, the propagate
//   vector (A ^ B_eff) used by the LZA, and the carry into every bit.
//
//   Optional feature macro: ADDER_OVF_FLAG_EN adds ovf_o, which flags
//   two's-complement overflow of the result.
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   valid_i/ready_o input handshake; ready_o = !valid_o || ready_i
//   Op_A_i, Op_B_i  operands (SWR bits)
//   C_i             carry in, ignored when op_i=1
//   op_i            0: A+B+C_i   1: A+~B+1
//   ready_i/valid_o output handshake
//   S_o             sum
//   C_o             carry out of bit SWR-1
//   Cn_o            carry into bit j, indexed [SWR-1:1]
//   P_o             propagate A ^ B_eff
//   ovf_o           signed overflow (ADDER_OVF_FLAG_EN only)
module full_adder_pg_pipe #(
    parameter int SWR = 55,
    parameter int SEG = 26
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           valid_i,
    output logic           ready_o,
    input  logic [SWR-1:0] Op_A_i,
    input  logic [SWR-1:0] Op_B_i,
    input  logic           C_i,
    input  logic           op_i,
    input  logic           ready_i,
    output logic           valid_o,
    output logic [SWR-1:0] S_o,
    output logic           C_o,
    output logic [SWR-1:1] Cn_o,
    output logic [SWR-1:0] P_o
`ifdef ADDER_OVF_FLAG_EN
    ,
    output logic           ovf_o
`endif
);

    localparam int NSEG = (SWR + SEG - 1) / SEG;

    // One global advance: every stage (bubbles included) moves together.
    logic adv;
    assign adv     = !valid_o || ready_i;
    assign ready_o = adv;

    // Each stage carries full-width vectors. Bits of segments not yet
    // processed hold the skewed operands. Bits of processed segments hold
    // the result: the sum rides in the A vector and P in the B vector. The
    // operand skew and the result deskew therefore share the same flops.
    for (genvar k = 0; k < NSEG; k++) begin : g_stage
        localparam int LO = k * SEG;
        localparam int HI = ((k + 1) * SEG > SWR) ? SWR - 1 : (k + 1) * SEG - 1;
        localparam int W  = HI - LO + 1;

        logic [SWR-1:0] in_a, in_b, nx_a, nx_b, a_q, b_q;
        logic [SWR-1:1] in_cn, nx_cn, cn_q;
        logic           in_c, in_op, in_v, c_nx, c_q, v_q;
        logic [W-1:0]   be, p;
        logic [W:0]     ch;

        if (k == 0) begin : g_src
            assign in_a  = Op_A_i;
            assign in_b  = Op_B_i;
            assign in_cn = '0;
            assign in_c  = op_i | C_i;
            assign in_op = op_i;
            assign in_v  = valid_i;
        end else begin : g_src
            assign in_a  = g_stage[k-1].a_q;
            assign in_b  = g_stage[k-1].b_q;
            assign in_cn = g_stage[k-1].cn_q;
            assign in_c  = g_stage[k-1].c_q;
            assign in_op = g_stage[k-1].g_op.op_q;
            assign in_v  = g_stage[k-1].v_q;
        end

        assign be    = in_b[HI:LO] ^ {W{in_op}};
        assign p     = in_a[HI:LO] ^ be;
        assign ch[0] = in_c;
        assign c_nx  = ch[W];

        for (genvar m = 0; m < SWR; m++) begin : g_bit
            if (m >= LO && m <= HI) begin : g_seg
                assign ch[m-LO+1] = (in_a[m] & be[m-LO]) | (p[m-LO] & ch[m-LO]);
                assign nx_a[m]    = p[m-LO] ^ ch[m-LO];
                assign nx_b[m]    = p[m-LO];
                if (m >= 1) begin : g_cn
                    assign nx_cn[m] = ch[m-LO];
                end
            end else begin : g_pass
                assign nx_a[m] = in_a[m];
                assign nx_b[m] = in_b[m];
                if (m >= 1) begin : g_cn
                    assign nx_cn[m] = in_cn[m];
                end
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                a_q  <= '0;
                b_q  <= '0;
                cn_q <= '0;
                c_q  <= 1'b0;
                v_q  <= 1'b0;
            end else if (adv) begin
                a_q  <= nx_a;
                b_q  <= nx_b;
                cn_q <= nx_cn;
                c_q  <= c_nx;
                v_q  <= in_v;
            end
        end

        // Mode bit travels with the data; the final stage no longer needs it.
        if (k < NSEG - 1) begin : g_op
            logic op_q;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    op_q <= 1'b0;
                end else if (adv) begin
                    op_q <= in_op;
                end
            end
        end
    end

    assign valid_o = g_stage[NSEG-1].v_q;
    assign S_o     = g_stage[NSEG-1].a_q;
    assign P_o     = g_stage[NSEG-1].b_q;
    assign Cn_o    = g_stage[NSEG-1].cn_q;
    assign C_o     = g_stage[NSEG-1].c_q;

`ifdef ADDER_OVF_FLAG_EN
    logic ovf_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else if (adv) begin
            ovf_q <= g_stage[NSEG-1].nx_cn[SWR-1] ^ g_stage[NSEG-1].c_nx;
        end
    end
    assign ovf_o = ovf_q;
`endif

endmodule
